// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and index-width helper for the round-robin lock arbiter
package arb_pkg;
  typedef enum logic {IDLE, OWNED} arb_state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search over req & ~mask starting at ptr
module rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic [N-1:0]    mask,
  output logic            valid,
  output logic [ID_W-1:0] idx
);
  logic [N-1:0] elig;
  assign elig = req & ~mask;
  // Scan farthest-first so the last hit written is the nearest to ptr
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx = ID_W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with grant locking and bounded hold time
module rr_lock_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W = id_w(N),
  localparam int HC_W = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            timeout
);
  arb_state_t state;
  logic [ID_W-1:0] ptr;
  logic [HC_W-1:0] hold_cnt;
  logic valid, own_req, others, hold_max, rel, pre, take;
  logic [ID_W-1:0] idx;
  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req  (request),
    .ptr  (ptr),
    .mask (grant),
    .valid(valid),
    .idx  (idx)
  );
  // grant is zero in IDLE, so it doubles as the owner mask
  assign own_req = |(request & grant);
  assign others = |(request & ~grant);
  assign hold_max = hold_cnt == HC_W'(MAX_HOLD - 1);
  assign rel = state == OWNED && !own_req;
  assign pre = state == OWNED && own_req && others && hold_max;
  assign take = valid && (state == IDLE || rel || pre);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= pre;
      if (take) begin
        state <= OWNED;
        grant <= N'(1) << idx;
        grant_id <= idx;
        busy <= 1'b1;
        hold_cnt <= '0;
        ptr <= (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
      end else if (rel) begin
        state <= IDLE;
        grant <= '0;
        grant_id <= '0;
        busy <= 1'b0;
        hold_cnt <= '0;
      end else if (state == OWNED) begin
        hold_cnt <= hold_max ? hold_cnt : hold_cnt + 1'b1;
      end
    end
  end
endmodule
